// File: rtl/parsing_bank_sched.sv
// parsing_bank_sched: 16-bank load/read sequencer with zero-pad rows; define PARSING_SCHED_RELOAD_SKIP_EN to allow re-read from IDLE
module parsing_bank_sched #(
  parameter int NUM_BANK = 16,
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 128,
  parameter int PAD      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_run,
  input  logic                i_wr_valid,
  input  logic [DATA_W-1:0]   i_wr_data,
  output logic                o_wr_ready,
  output logic [NUM_BANK-1:0] o_ena,
  output logic [NUM_BANK-1:0] o_wea,
  output logic [ADDR_W-1:0]   o_addra,
  output logic [DATA_W-1:0]   o_dia,
  output logic [NUM_BANK-1:0] o_enb,
  output logic [ADDR_W-1:0]   o_addrb,
  output logic                o_rd_valid,
  output logic                o_pad,
  output logic                o_load_done,
  output logic                o_done,
  output logic                o_busy
);
  localparam int ROWS = DEPTH + 2 * PAD;
  localparam int RW   = $clog2(ROWS + 1);
  localparam int BW   = $clog2(NUM_BANK);
`ifdef PARSING_SCHED_RELOAD_SKIP_EN
  localparam logic SKIP = 1'b1;
`else
  localparam logic SKIP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, READY, READ, DONE} state_t;
  state_t state, state_nx;
  logic [BW-1:0] bank;
  logic [ADDR_W-1:0] addr;
  logic [RW-1:0] row;
  logic wr_acc, last_wr, last_addr, step, last_row, pad_row;
  always_comb begin
    wr_acc     = state == LOAD && i_wr_valid;
    last_addr  = addr == ADDR_W'(DEPTH - 1);
    last_wr    = last_addr && bank == BW'(NUM_BANK - 1);
    step       = state == READ && i_run;
    last_row   = row == RW'(ROWS - 1);
    pad_row    = row < RW'(PAD) || row >= RW'(PAD + DEPTH);
    state_nx   = state == IDLE  ? (i_start ? LOAD : (SKIP && i_run) ? READ : IDLE) :
                 state == LOAD  ? ((wr_acc && last_wr) ? READY : LOAD) :
                 state == READY ? (i_run ? READ : READY) :
                 state == READ  ? ((step && last_row) ? DONE : READ) : IDLE;
    o_wr_ready = state == LOAD;
    o_enb      = {NUM_BANK{step && !pad_row}};
    o_addrb    = (step && !pad_row) ? ADDR_W'(row - RW'(PAD)) : '0;
    o_done     = state == DONE;
    o_busy     = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bank        <= '0;
      addr        <= '0;
      row         <= '0;
      o_ena       <= '0;
      o_wea       <= '0;
      o_addra     <= '0;
      o_dia       <= '0;
      o_rd_valid  <= 1'b0;
      o_pad       <= 1'b0;
      o_load_done <= 1'b0;
    end else begin
      state       <= state_nx;
      o_ena       <= wr_acc ? NUM_BANK'(1) << bank : '0;
      o_wea       <= wr_acc ? NUM_BANK'(1) << bank : '0;
      o_load_done <= wr_acc && last_wr;
      o_rd_valid  <= step;
      o_pad       <= step && pad_row;
      if (wr_acc) begin
        o_addra <= addr;
        o_dia   <= i_wr_data;
        addr    <= last_addr ? '0 : addr + 1'b1;
        bank    <= last_addr ? bank + 1'b1 : bank;
      end
      if (state == IDLE) begin
        bank <= '0;
        addr <= '0;
        row  <= '0;
      end else if (step) begin
        row <= last_row ? '0 : row + 1'b1;
      end
    end
  end
endmodule

// File: doc/parsing_bank_sched.md
Name: parsing_bank_sched

Overview:
- Controller that sequences the 16-bank input buffer of the parsing/zero-padding datapath.
- Two phases:
  - Load: routes a single write stream into the banks in order, bank 0 first, ascending address within each bank.
  - Read: issues the same read address to all banks in parallel, and inserts zero-padding rows before and after the valid rows.
- Sits between the DMA/stream source and the bank BRAMs; replaces bench-driven bank fill with hardware sequencing.

Parameters:
- NUM_BANK, 16, number of BRAM banks; one-hot enable width.
- DEPTH, 128, words loaded and read per bank.
- ADDR_W, 9, bank address width.
- DATA_W, 128, bank word width.
- PAD, 1, zero-padding rows emitted before and after the DEPTH valid rows (0..4).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_start  in  1  begin load session (sampled in IDLE).
- i_run  in  1  begin/continue read phase; deassertion stalls the read.
- i_wr_valid  in  1  write beat valid.
- i_wr_data  in  DATA_W  write beat data.
- o_wr_ready  out  1  write beat accepted when valid&ready.
- o_ena  out  NUM_BANK  port-A bank enable, one-hot.
- o_wea  out  NUM_BANK  port-A write enable, equal to o_ena.
- o_addra  out  ADDR_W  port-A address.
- o_dia  out  DATA_W  port-A write data.
- o_enb  out  NUM_BANK  port-B read enable; all ones or zero.
- o_addrb  out  ADDR_W  port-B read address, common to all banks.
- o_rd_valid  out  1  bank read data / padding beat valid this cycle.
- o_pad  out  1  qualifies o_rd_valid beat as a zero-padding row.
- o_load_done  out  1  one-cycle pulse, load phase complete.
- o_done  out  1  one-cycle pulse, read phase complete.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: every output is 0. State = IDLE. Bank index, address and row counters = 0.
- Reset mid-operation: returns to IDLE the next edge and drops the partial session. BRAM contents are not cleared.

States: IDLE, LOAD, READY, READ, DONE.

IDLE:
- i_start=1 -> LOAD.
- i_run is ignored. If i_start and i_run are high together, i_start wins.

LOAD:
- o_wr_ready=1.
- Each accepted beat writes bank b at address a. Outputs are registered, so o_ena/o_wea/o_addra/o_dia appear 1 cycle after the handshake and o_ena=1<<b for that one cycle.
- Without a beat, o_ena/o_wea=0 the next cycle. o_addra/o_dia hold their last values.
- a increments per beat. At a=DEPTH-1, a wraps to 0 and b increments.
- Beat (b=NUM_BANK-1, a=DEPTH-1) accepted -> READY. o_wr_ready drops in the same cycle the state changes. o_load_done pulses on the cycle that final write is presented to the banks.
- i_start and i_run are ignored in LOAD.

READY:
- i_run=1 -> READ.
- o_wr_ready=0.

READ:
- Row counter r runs 0..DEPTH+2*PAD-1 and advances only on cycles with i_run=1.
- i_run=0 stalls: r holds, o_enb=0, and o_rd_valid=0 one cycle later.
- Padding rows (r<PAD or r>=PAD+DEPTH): o_enb=0.
- Data rows: o_enb all ones, o_addrb=r-PAD.
- o_rd_valid and o_pad are the step qualifiers delayed 1 cycle, matching BRAM read latency 1. o_pad=1 only on padding beats.
- After the last row step -> DONE.

DONE:
- o_done=1 for one cycle, timed with the final o_rd_valid beat.
- Next state IDLE.

Beat totals:
- Exactly NUM_BANK*DEPTH write beats per load.
- Exactly DEPTH+2*PAD o_rd_valid beats per read.
- PAD=0: no o_pad beats.

Optional Feature:
- Macro: PARSING_SCHED_RELOAD_SKIP_EN.
- Defined: i_run=1 in IDLE (with i_start=0) enters READ directly, re-reading the previously loaded banks. o_load_done does not pulse.
- Undefined: i_run in IDLE is ignored; every read requires a preceding full load.

Test Plan:
- Full load, continuous i_wr_valid, data = bank index replicated per byte (0x00.., 0x01.., ... 0x0F..) -> o_wea walks 0x0001..0x8000 with 128 writes each at o_addra 0..127; o_load_done pulses once after beat 2048; state READY.
- Load with i_wr_valid toggling every other cycle -> still 2048 writes, no address skips or repeats; o_ena=0 on idle cycles.
- i_run=1 held, PAD=1 -> 130 o_rd_valid beats; beats 0 and 129 have o_pad=1 and o_enb=0; beats 1..128 read o_addrb 0..127 with o_enb=0xFFFF; o_done coincides with beat 129.
- i_run dropped 5 cycles at row 40 -> o_rd_valid gap of 5 cycles; resume at o_addrb 39 with no repeat or skip; total beats still 130.
- rst=1 during LOAD at bank 3 address 50 -> all outputs 0 the next cycle, IDLE; i_run ignored; a new i_start restarts at bank 0 address 0.
- Macro defined: after one full load+read, assert i_run in IDLE -> 130 beats again with o_load_done silent; macro undefined -> no response.
